wb_pipe_register: RTL
=====================

Name: wb_pipe_register

Overview:
- Parametrised memory-to-writeback pipeline register for the pipelined Y86 core; successor to the plain M->W latch.
- Adds stall (hold), bubble (NOP injection), a status field, and a sticky halt freeze when a non-AOK status reaches writeback.
- Adds saturating stall/bubble event counters and a sticky control-error flag for debug.
- Sits between the memory stage and the writeback/register-file logic; driven by the pipeline control unit.

Parameters:
WORD_W, 64, width of valC/valP/valA/valB/valE/valM
REG_W, 4, width of register IDs regA/regB
ICODE_W, 4, width of icode
STAT_W, 3, width of stat
CNT_W, 32, width of each event counter
NOP_ICODE, 4'h1, icode loaded on bubble/reset
RNONE, 4'hF, register ID loaded on bubble/reset
STAT_AOK, 3'd1, normal status
STAT_BUB, 3'd0, status loaded on bubble/reset

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
w_stall  in  1  hold current W contents
w_bubble  in  1  load NOP bubble
m_icode  in  ICODE_W  memory-stage icode
m_regA, m_regB  in  REG_W  register IDs
m_valC, m_valP, m_valA, m_valB, m_valE, m_valM  in  WORD_W  data fields
m_cond  in  1  condition flag
m_stat  in  STAT_W  memory-stage status
w_icode  out  ICODE_W  registered icode
w_regA, w_regB  out  REG_W  registered IDs
w_valC, w_valP, w_valA, w_valB, w_valE, w_valM  out  WORD_W  registered data
w_cond  out  1  registered flag
w_stat  out  STAT_W  registered status
halted  out  1  sticky: W holds a non-AOK, non-bubble status
ctl_err  out  1  sticky: stall and bubble asserted together
stall_cnt  out  CNT_W  cycles in which a stall took effect
bubble_cnt  out  CNT_W  cycles in which a bubble took effect

Behaviour:
- Reset (asynchronous, immediate, regardless of clock):
  - w_icode=NOP_ICODE, w_regA=w_regB=RNONE, all w_val*=0, w_cond=0, w_stat=STAT_BUB.
  - halted=0, ctl_err=0, both counters=0.
  - Deassertion takes effect at the next rising edge; reset mid-operation discards all contents.
- Each rising edge when not reset, priority highest first:
  - 1. halted=1: all W fields, counters and halted hold. ctl_err may still set.
  - 2. w_bubble=1: load the bubble values (same as reset field values); bubble_cnt+1.
  - 3. w_stall=1: all W fields hold; stall_cnt+1.
  - 4. Otherwise load every m_* field into its w_* counterpart; latency is 1 cycle.
- Simultaneous stall and bubble: bubble wins. ctl_err sets on that edge and stays set until reset, including while halted.
- Halt:
  - halted sets on the edge that loads m_stat not equal to STAT_AOK and not equal to STAT_BUB.
  - halted is visible in the same cycle the bad w_stat appears.
  - Once set, it is cleared only by reset.
- Counters:
  - Unsigned and saturating at all-ones; no wrap-around.
  - Do not count while halted.
  - Stall and bubble on the same edge counts only bubble_cnt.
- No combinational input-to-output paths; all outputs are registered.

Test Plan:
- Reset pulse asserted between clock edges -> outputs immediately show w_icode=1, w_regA=F, w_regB=F, w_val*=0, w_stat=0, counters=0.
- m_icode=6, m_valE=64'h10, m_stat=1, no control -> after 1 edge w_icode=6, w_valE=64'h10, w_stat=1, halted=0.
- Load m_valE=64'hAA, then w_stall=1 for 3 edges while m_valE changes to 64'hBB -> w_valE stays 64'hAA; stall_cnt=3.
- w_stall=1 and w_bubble=1 on one edge -> w_icode=1, w_regA=F, w_stat=0, bubble_cnt=1, stall_cnt unchanged, ctl_err=1 and sticky.
- m_stat=2 (HLT) loaded -> halted=1; later m_icode/m_stat changes, stall and bubble pulses -> W fields and counters frozen; reset clears halted.
- CNT_W=4, w_stall held 20 edges -> stall_cnt reaches 4'hF and stays there.

Source files
------------

// File: rtl/wb_pipe_register.sv
// wb_pipe_register
// Memory-to-writeback pipeline register for the pipelined Y86 core.
//
// Each rising edge loads the memory-stage bundle (m_*) into the writeback
// bundle (w_*). The pipeline control unit can hold the register (w_stall)
// or replace its contents with a NOP bubble (w_bubble). Bubble outranks
// stall.
//
// Once an instruction with a status other than AOK or bubble reaches
// writeback, the register freezes: all fields and counters hold until
// reset.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   w_stall, w_bubble  pipeline control (hold / inject NOP)
//   m_*                memory-stage fields: icode, regA/B, valC/P/A/B/E/M,
//                      cond, stat
//   w_*                registered writeback fields (same set as m_*)
//   halted             sticky: W holds a non-AOK, non-bubble status
//   ctl_err            sticky: stall and bubble were requested together
//   stall_cnt          saturating count of edges where a stall took effect
//   bubble_cnt         saturating count of edges where a bubble took effect
//
// Control semantics: w_stall and w_bubble are level signals sampled at each
// rising edge. There is no handshake. Every output is driven directly by a
// flop, so no input reaches an output combinationally.
module wb_pipe_register #(
  parameter int                WORD_W    = 64,
  parameter int                REG_W     = 4,
  parameter int                ICODE_W   = 4,
  parameter int                STAT_W    = 3,
  parameter int                CNT_W     = 32,
  parameter logic [ICODE_W-1:0] NOP_ICODE = 4'h1,
  parameter logic [REG_W-1:0]   RNONE     = 4'hF,
  parameter logic [STAT_W-1:0]  STAT_AOK  = 3'd1,
  parameter logic [STAT_W-1:0]  STAT_BUB  = 3'd0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               w_stall,
  input  logic               w_bubble,
  input  logic [ICODE_W-1:0] m_icode,
  input  logic [REG_W-1:0]   m_regA,
  input  logic [REG_W-1:0]   m_regB,
  input  logic [WORD_W-1:0]  m_valC,
  input  logic [WORD_W-1:0]  m_valP,
  input  logic [WORD_W-1:0]  m_valA,
  input  logic [WORD_W-1:0]  m_valB,
  input  logic [WORD_W-1:0]  m_valE,
  input  logic [WORD_W-1:0]  m_valM,
  input  logic               m_cond,
  input  logic [STAT_W-1:0]  m_stat,
  output logic [ICODE_W-1:0] w_icode,
  output logic [REG_W-1:0]   w_regA,
  output logic [REG_W-1:0]   w_regB,
  output logic [WORD_W-1:0]  w_valC,
  output logic [WORD_W-1:0]  w_valP,
  output logic [WORD_W-1:0]  w_valA,
  output logic [WORD_W-1:0]  w_valB,
  output logic [WORD_W-1:0]  w_valE,
  output logic [WORD_W-1:0]  w_valM,
  output logic               w_cond,
  output logic [STAT_W-1:0]  w_stat,
  output logic               halted,
  output logic               ctl_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Decoded action for this edge; a frozen register takes none of them.
  logic do_bubble;
  logic do_stall;
  logic do_load;
  logic load_bad_stat;

  always_comb begin
    do_bubble     = !halted && w_bubble;
    do_stall      = !halted && !w_bubble && w_stall;
    do_load       = !halted && !w_bubble && !w_stall;
    // Only a real instruction with a fault status freezes the pipe; bubbles
    // carry STAT_BUB and must pass through harmlessly.
    load_bad_stat = (m_stat != STAT_AOK) && (m_stat != STAT_BUB);
  end

  // W data fields
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_icode <= NOP_ICODE;
      w_regA  <= RNONE;
      w_regB  <= RNONE;
      w_valC  <= '0;
      w_valP  <= '0;
      w_valA  <= '0;
      w_valB  <= '0;
      w_valE  <= '0;
      w_valM  <= '0;
      w_cond  <= 1'b0;
      w_stat  <= STAT_BUB;
    end else if (do_bubble) begin
      w_icode <= NOP_ICODE;
      w_regA  <= RNONE;
      w_regB  <= RNONE;
      w_valC  <= '0;
      w_valP  <= '0;
      w_valA  <= '0;
      w_valB  <= '0;
      w_valE  <= '0;
      w_valM  <= '0;
      w_cond  <= 1'b0;
      w_stat  <= STAT_BUB;
    end else if (do_load) begin
      w_icode <= m_icode;
      w_regA  <= m_regA;
      w_regB  <= m_regB;
      w_valC  <= m_valC;
      w_valP  <= m_valP;
      w_valA  <= m_valA;
      w_valB  <= m_valB;
      w_valE  <= m_valE;
      w_valM  <= m_valM;
      w_cond  <= m_cond;
      w_stat  <= m_stat;
    end
  end

  // Sticky flags. halted rises together with the faulting w_stat.
  // ctl_err is recorded even while frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted  <= 1'b0;
      ctl_err <= 1'b0;
    end else begin
      if (do_load && load_bad_stat) begin
        halted <= 1'b1;
      end
      if (w_stall && w_bubble) begin
        ctl_err <= 1'b1;
      end
    end
  end

  // Saturating event counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (do_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (do_bubble && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule
